// File: rtl/aes_fifo_pkg.sv
// Shared definitions for the AES block-buffer FIFO write-side logic.
// Holds the arbiter state encoding and the default tdata width.
package aes_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 128;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT0 = ST_GRANT0,
    GRANT1 = ST_GRANT1
  } arb_state_t;

endpackage

// File: rtl/fifo_write_arbiter.sv
// Packet-granular 2:1 AXI-Stream arbiter for the AES FIFO write port, with MAX_BEATS packet cap.
// Round-robin by default; define FIFO_WRARB_STRICT_PRIO_EN to make s0 always win in IDLE.
//
// state  | meaning
// IDLE   | no grant; arbitrate among valid requesters, nothing forwarded
// GRANT0 | s0 owns the write port until a beat with m_tlast is accepted
// GRANT1 | s1 owns the write port until a beat with m_tlast is accepted
module fifo_write_arbiter
  import aes_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_BEATS  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic                  s0_tlast,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic                  s1_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tid,
  output logic                  busy,
  output logic                  overrun_err
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BEATS - 1);

  arb_state_t           state, state_nxt;
  logic                 rr_last;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 at_max;
  logic                 src_last;
  logic                 both_pick_s1;
  logic                 accept;
  logic                 pkt_end;

  assign at_max = (beat_cnt == LAST_CNT);

  // rr_last names the requester served last, so the other one wins a tie.
`ifdef FIFO_WRARB_STRICT_PRIO_EN
  assign both_pick_s1 = 1'b0;
`else
  assign both_pick_s1 = ~rr_last;
`endif

  always_comb begin
    state_nxt = state;
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tid     = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    busy      = 1'b0;
    src_last  = 1'b0;
    case (state)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) state_nxt = both_pick_s1 ? GRANT1 : GRANT0;
        else if (s0_tvalid)         state_nxt = GRANT0;
        else if (s1_tvalid)         state_nxt = GRANT1;
      end
      GRANT0: begin
        m_tdata   = s0_tdata;
        m_tvalid  = s0_tvalid;
        s0_tready = m_tready;
        src_last  = s0_tlast;
        m_tlast   = s0_tlast || at_max;
        busy      = 1'b1;
        if (s0_tvalid && m_tready && m_tlast) state_nxt = IDLE;
      end
      GRANT1: begin
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        s1_tready = m_tready;
        m_tid     = 1'b1;
        src_last  = s1_tlast;
        m_tlast   = s1_tlast || at_max;
        busy      = 1'b1;
        if (s1_tvalid && m_tready && m_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = m_tvalid && m_tready;
  assign pkt_end = accept && m_tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      beat_cnt    <= '0;
      overrun_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pkt_end) begin
        rr_last  <= m_tid;
        beat_cnt <= '0;
        // Forced cut: the source's tail is arbitrated again as a fresh packet.
        if (!src_last) overrun_err <= 1'b1;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef FORMAL
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    hold_q <= !reset && m_tvalid && !m_tready;
    data_q <= m_tdata;
    if (!reset) begin
      assert (!(s0_tready && s1_tready));
      assert (state != IDLE || !m_tvalid);
      assert (beat_cnt <= LAST_CNT);
      if (hold_q) assert (m_tdata == data_q);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed packet scenarios plus
// randomized AXI-S producers, compared every cycle against a packet-level model.
module tb_fifo_write_arbiter;

  localparam int DW = 128;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tready, s0_tlast;
  logic          s1_tvalid, s1_tready, s1_tlast;
  logic          m_tvalid, m_tready, m_tlast, m_tid, busy, overrun_err;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tid(m_tid), .busy(busy), .overrun_err(overrun_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Producer queues: bit DW is the beat's tlast.
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  bit   shown0 = 0, shown1 = 0;
  int   pv = 100, pr = 100;
  bit   rdy_rand = 0;
  logic rdy_req = 1'b1, rst_req = 1'b1;

  // Model: who owns the port, who won last, beats taken in this packet.
  int owner = -1, last_win = 1, sent = 0;
  bit ovr = 0;

  bit            v0, v1, l0, l1, rdy, rst;
  logic [DW-1:0] d0, d1;

  logic [DW-1:0] log_data[$];
  bit            log_tid[$];
  bit            log_last[$];
  int            log_cyc[$];

  function automatic logic [DW-1:0] mk(int s, int p, int b);
    logic [DW-1:0] r;
    r = '0;
    r[95:64] = s;
    r[63:32] = p;
    r[31:0]  = b;
    r[127:96] = 32'hA5A5_0000 + b;
    return r;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_pkt(int s, int p, int n, int last_at);
    for (int b = 0; b < n; b++) begin
      if (s == 0) q0.push_back({(b == last_at), mk(s, p, b)});
      else        q1.push_back({(b == last_at), mk(s, p, b)});
    end
  endtask

  task automatic step();
    bit e_valid, e_last, e_acc;
    logic [DW-1:0] e_data;
    if (!shown0 && q0.size() > 0 && $urandom_range(99) < pv) shown0 = 1;
    if (!shown1 && q1.size() > 0 && $urandom_range(99) < pv) shown1 = 1;
    v0 = shown0; l0 = shown0 && q0[0][DW]; d0 = shown0 ? q0[0][DW-1:0] : '0;
    v1 = shown1; l1 = shown1 && q1[0][DW]; d1 = shown1 ? q1[0][DW-1:0] : '0;
    rdy = rdy_rand ? ($urandom_range(99) < pr) : rdy_req;
    rst = rst_req;
    s0_tvalid = v0; s0_tlast = l0; s0_tdata = d0;
    s1_tvalid = v1; s1_tlast = l1; s1_tdata = d1;
    m_tready = rdy; reset = rst;
    @(negedge clk);
    e_valid = (owner == 0 && v0) || (owner == 1 && v1);
    e_data  = (owner == 0) ? d0 : (owner == 1) ? d1 : '0;
    e_last  = (owner >= 0) && (((owner == 0) ? l0 : l1) || sent == MB - 1);
    chk("busy", busy, owner >= 0);
    chk("m_tvalid", m_tvalid, e_valid);
    chk("m_tdata", m_tdata, e_data);
    chk("m_tlast", m_tlast, e_last);
    chk("m_tid", m_tid, owner == 1);
    chk("s0_tready", s0_tready, owner == 0 && rdy);
    chk("s1_tready", s1_tready, owner == 1 && rdy);
    chk("overrun_err", overrun_err, ovr);
    e_acc = e_valid && rdy;
    if (!rst && m_tvalid && m_tready) begin
      log_data.push_back(m_tdata); log_tid.push_back(m_tid);
      log_last.push_back(m_tlast); log_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      owner = -1; last_win = 1; sent = 0; ovr = 0;
    end else if (owner < 0) begin
`ifdef FIFO_WRARB_STRICT_PRIO_EN
      if (v0) owner = 0; else if (v1) owner = 1;
`else
      if (v0 && v1) owner = 1 - last_win; else if (v0) owner = 0; else if (v1) owner = 1;
`endif
    end else if (e_acc) begin
      if (owner == 0) begin void'(q0.pop_front()); shown0 = 0; end
      else            begin void'(q1.pop_front()); shown1 = 0; end
      if (e_last) begin
        if (!((owner == 0) ? l0 : l1)) ovr = 1;
        last_win = owner; owner = -1; sent = 0;
      end else sent++;
    end
    #1;
  endtask

  task automatic reset_begin();
    rst_req = 1'b1; rdy_rand = 0; rdy_req = 1'b1; pv = 100;
    step();
    q0.delete(); q1.delete(); shown0 = 0; shown1 = 0;
    log_data.delete(); log_tid.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic reset_end();
    step();
    rst_req = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic need(string nm, int n);
    chk(nm, log_data.size(), n);
  endtask

  initial begin
    int total;
    int bound;
    logic [DW-1:0] hold_v;
    reset = 1'b1; m_tready = 1'b1;
    s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0; s0_tdata = '0; s1_tdata = '0;

    // Both valid at reset release, 3-beat packets each.
    reset_begin();
    push_pkt(0, 0, 3, 2); push_pkt(1, 0, 3, 2);
    shown0 = 1; shown1 = 1;
    reset_end();
    chk("rst_busy", busy, 0); chk("rst_valid", m_tvalid, 0); chk("rst_ovr", overrun_err, 0);
    run(12);
    need("t1_count", 6);
    if (log_data.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("t1_tid", log_tid[i], i >= 3);
        chk("t1_data", log_data[i], mk(i / 3, 0, i % 3));
        chk("t1_last", log_last[i], (i % 3) == 2);
      end
      chk("t1_gap", log_cyc[3] - log_cyc[2], 2);
      chk("t1_b2b", log_cyc[1] - log_cyc[0], 1);
    end

    // s1 alone; s0 arrives mid-packet and must wait.
    reset_begin();
    push_pkt(1, 1, 2, 1);
    reset_end();
    run(2);
    push_pkt(0, 1, 1, 0);
    run(8);
    need("t2_count", 3);
    if (log_data.size() == 3) begin
      chk("t2_tid0", log_tid[0], 1); chk("t2_tid1", log_tid[1], 1); chk("t2_tid2", log_tid[2], 0);
      chk("t2_data2", log_data[2], mk(0, 1, 0));
    end

    // Backpressure on beat 2 of a 3-beat packet.
    reset_begin();
    push_pkt(0, 2, 3, 2);
    reset_end();
    bound = 0;
    while (log_data.size() < 1 && bound < 10) begin step(); bound++; end
    rdy_req = 1'b0;
    repeat (4) begin
      step();
      chk("t3_hold_data", m_tdata, mk(0, 2, 1));
      chk("t3_hold_count", log_data.size(), 1);
    end
    rdy_req = 1'b1;
    run(6);
    need("t3_count", 3);
    if (log_data.size() == 3)
      for (int i = 0; i < 3; i++) chk("t3_data", log_data[i], mk(0, 2, i));

    // 18-beat packet against MAX_BEATS=16, s1 waiting with one beat.
    reset_begin();
    push_pkt(0, 3, 18, 17); push_pkt(1, 3, 1, 0);
    reset_end();
    run(30);
    need("t4_count", 19);
    if (log_data.size() == 19) begin
      chk("t4_cut_last", log_last[15], 1);
      chk("t4_cut_data", log_data[15], mk(0, 3, 15));
      chk("t4_s1_tid", log_tid[16], 1);
      chk("t4_s1_data", log_data[16], mk(1, 3, 0));
      chk("t4_tail_tid", log_tid[17], 0);
      chk("t4_tail_data", log_data[17], mk(0, 3, 16));
      chk("t4_tail_last", log_last[18], 1);
    end
    chk("t4_overrun", overrun_err, 1);

    // Reset after 2 of 5 beats.
    reset_begin();
    push_pkt(0, 4, 5, 4);
    reset_end();
    bound = 0;
    while (log_data.size() < 2 && bound < 10) begin step(); bound++; end
    rst_req = 1'b1;
    step();
    chk("t5_busy", busy, 0); chk("t5_valid", m_tvalid, 0);
    chk("t5_s0_tready", s0_tready, 0); chk("t5_ovr", overrun_err, 0);
    q0.delete(); shown0 = 0;
    rst_req = 1'b0;
    run(3);

    // Continuous 1-beat packets from both sides.
    reset_begin();
    for (int p = 0; p < 4; p++) begin push_pkt(0, p, 1, 0); push_pkt(1, p, 1, 0); end
    shown0 = 1; shown1 = 1;
    reset_end();
    run(20);
    need("t6_count", 8);
    if (log_data.size() == 8)
      for (int i = 0; i < 8; i++) begin
`ifdef FIFO_WRARB_STRICT_PRIO_EN
        chk("t6_tid", log_tid[i], i >= 4);
`else
        chk("t6_tid", log_tid[i], i % 2);
`endif
        chk("t6_last", log_last[i], 1);
      end

    // Randomized traffic with backpressure and occasional overruns.
    reset_begin();
    total = 0;
    for (int p = 0; p < 40; p++) begin
      int n0, n1;
      n0 = $urandom_range(1, 20); n1 = $urandom_range(1, 20);
      push_pkt(0, 100 + p, n0, n0 - 1); push_pkt(1, 100 + p, n1, n1 - 1);
      total += n0 + n1;
    end
    reset_end();
    rdy_rand = 1; pr = 70; pv = 60;
    bound = 0;
    while ((q0.size() > 0 || q1.size() > 0) && bound < 6000) begin step(); bound++; end
    run(4);
    chk("rand_drain", q0.size() + q1.size(), 0);
    chk("rand_beats", log_data.size(), total);
    hold_v = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
